// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N   = 4;
  localparam int ARB_IDW = 2;

endpackage

// File: rtl/priority_encoder4.sv
// Combinational 4-input priority encoder: the highest set index wins.
module priority_encoder4
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_IDW-1:0] idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    else             idx = 2'd0;
  end

endmodule

// File: rtl/priority_arbiter4.sv
// Registered single-owner arbiter with release handshake and hold watchdog.
// `release` is a reserved word, so that input is named rel. Define PRIORITY_ARBITER4_RR_EN for round robin.
module priority_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ARB_N-1:0]   req,
  input  logic               rel,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t          state, state_n;
  logic [HW-1:0]       hold_cnt, hold_n;
  logic [ARB_N-1:0]    gnt_n;
  logic [ARB_IDW-1:0]  id_n;
  logic                valid_n, timeout_n;
  logic [ARB_IDW-1:0]  full_idx, win;
  logic                any_req;
  logic                owner_req, wd_hit;

  priority_encoder4 u_full (
    .req   (req),
    .idx   (full_idx),
    .valid (any_req)
  );

`ifdef PRIORITY_ARBITER4_RR_EN
  logic [ARB_IDW-1:0] last_id;
  logic [ARB_N-1:0]   masked_req;
  logic [ARB_IDW-1:0] masked_idx;
  logic               masked_valid;

  // Only requesters below the previous owner compete first, giving 3->2->1->0->3.
  assign masked_req = req & ((4'b0001 << last_id) - 4'b0001);

  priority_encoder4 u_masked (
    .req   (masked_req),
    .idx   (masked_idx),
    .valid (masked_valid)
  );

  assign win = masked_valid ? masked_idx : full_idx;

  always_ff @(posedge clk) begin
    if (reset)
      last_id <= '0;
    else if (state == IDLE && any_req)
      last_id <= win;
  end
`else
  assign win = full_idx;
`endif

  assign owner_req = req[gnt_id];
  assign wd_hit    = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      timeout   <= timeout_n;
      hold_cnt  <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    id_n      = gnt_id;
    valid_n   = gnt_valid;
    timeout_n = 1'b0;
    hold_n    = hold_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = GRANT;
          gnt_n   = ARB_N'(1) << win;
          id_n    = win;
          valid_n = 1'b1;
          hold_n  = HW'(1);
        end else begin
          gnt_n   = '0;
          id_n    = '0;
          valid_n = 1'b0;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (rel || !owner_req || wd_hit) begin
          state_n   = IDLE;
          gnt_n     = '0;
          id_n      = '0;
          valid_n   = 1'b0;
          hold_n    = '0;
          // A release or dropped request on the same edge outranks the watchdog.
          timeout_n = wd_hit && !rel && owner_req;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
